// File: rtl/pc_predict_unit.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit counters; branch/jump
// outcomes resolved in ID correct mispredictions with a same-cycle redirect.
module pc_predict_unit #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'hBFC0_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_branch,
  input  logic            id_equ,
  input  logic            id_jump,
  input  logic            id_jumpr,
  input  logic [XLEN-1:0] id_imme32,
  input  logic [25:0]     id_target,
  input  logic [XLEN-1:0] id_rs,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pred_target,
  output logic            flush_if,
  output logic            redirect
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] btb_target [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]  look_idx;
  logic [TAGW-1:0] look_tag;
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_en;
  logic            upd_hit;

  logic            taken_a;
  logic [XLEN-1:0] target_a;
  logic            mispredict;
  logic [XLEN-1:0] pc_next;

  // Lookup reads the array before this cycle's update lands, so a same-index
  // update is only seen from the next cycle.
  assign look_idx    = pc[IDX+1:2];
  assign look_tag    = pc[XLEN-1:IDX+2];
  assign pred_taken  = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag) && btb_ctr[look_idx][1];
  assign pred_target = pred_taken ? btb_target[look_idx] : '0;

  assign taken_a = id_jump | (id_branch & id_equ);

  always_comb begin
    target_a = '0;
    if (id_jump && id_jumpr)
      target_a = id_rs;
    else if (id_jump)
      target_a = {id_pc[XLEN-1:28], id_target, 2'b00};
    else if (id_branch)
      target_a = id_pc + PC_STEP + (id_imme32 << 2);
  end

  // A prediction on a non-control-flow instruction is an alias and must be undone.
  assign mispredict = id_valid &&
                      ((taken_a != id_pred_taken) ||
                       (taken_a && (target_a != id_pred_target)) ||
                       (id_pred_taken && !id_branch && !id_jump));

  assign redirect = mispredict;
  assign flush_if = mispredict;

  always_comb begin
    pc_next = pc + PC_STEP;
    if (mispredict)
      pc_next = taken_a ? target_a : id_pc + PC_STEP;
    else if (stall)
      pc_next = pc;
    else if (pred_taken)
      pc_next = pred_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  assign upd_idx = id_pc[IDX+1:2];
  assign upd_tag = id_pc[XLEN-1:IDX+2];
  assign upd_en  = id_valid & (id_branch | id_jump);
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (taken_a) begin
          if (btb_ctr[upd_idx] != 2'd3)
            btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
          btb_target[upd_idx] <= target_a;
        end else if (btb_ctr[upd_idx] != 2'd0) begin
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
        end
      end else if (taken_a) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= target_a;
        btb_ctr[upd_idx]    <= id_jump ? 2'd3 : 2'd2;
      end
    end
  end

endmodule

// File: doc/pc_predict_unit.md
PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, sets the address and data width.
REQ-002 Parameter BTB_ENTRIES, default 16, sets the BTB entry count; it SHALL be a power of 2 and at least 2; IDX = log2(BTB_ENTRIES).
REQ-003 Parameter RESET_PC, default 32'hBFC0_0000, sets the fetch address after reset.
REQ-004 The ports SHALL be as follows:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  holds the fetch PC.
- pc  out  XLEN  current fetch address (registered).
- pred_taken  out  1  BTB predicts taken for pc.
- pred_target  out  XLEN  predicted target for pc; 0 when not predicted.
- id_valid  in  1  ID-stage control-flow instruction is valid this cycle.
- id_pc  in  XLEN  PC of the ID instruction.
- id_branch  in  1  ID instruction is a conditional branch.
- id_equ  in  1  branch condition is true.
- id_jump  in  1  ID instruction is j, jal or jr.
- id_jumpr  in  1  register jump; qualified by id_jump.
- id_imme32  in  XLEN  sign-extended branch offset, in words.
- id_target  in  26  jump target field.
- id_rs  in  XLEN  forwarded rs value.
- id_pred_taken  in  1  pred_taken that travelled with the ID instruction.
- id_pred_target  in  XLEN  pred_target that travelled with it.
- flush_if  out  1  the IF instruction is wrong-path.
- redirect  out  1  a mispredict redirect is taking place this cycle.

Function
REQ-005 The BTB index SHALL be pc[IDX+1:2] and the tag SHALL be pc[XLEN-1:IDX+2].
- Each entry holds a valid bit, a tag, an XLEN-bit target and a 2-bit saturating counter.
REQ-006 Lookup SHALL be combinational on pc: pred_taken = valid & tag match & counter[1]; pred_target = target when pred_taken, else 0.
REQ-007 The actual outcome SHALL be computed as follows:
- taken_a = id_jump | (id_branch & id_equ).
- Target when id_jumpr: id_rs.
- Target when id_jump: {id_pc[XLEN-1:28], id_target, 2'b00}.
- Target when id_branch: id_pc + 4 + (id_imme32 << 2), all modulo 2^XLEN.
REQ-008 mispredict SHALL be asserted when id_valid and any of the following holds:
- taken_a != id_pred_taken;
- taken_a and target_a != id_pred_target;
- id_pred_taken while neither id_branch nor id_jump is set (aliasing).
REQ-009 redirect and flush_if SHALL equal mispredict, combinationally, in the same cycle.
REQ-010 The next-pc priority SHALL be:
- mispredict → target_a if taken_a, else id_pc + 4;
- else stall → pc holds;
- else pred_taken → pred_target;
- else pc + 4.
REQ-011 A mispredict SHALL update pc on the next edge even while stall = 1.
REQ-012 pc + 4 SHALL wrap modulo 2^XLEN with no error indication.
REQ-013 The BTB SHALL update on a rising edge only when id_valid & (id_branch | id_jump); the entry is selected by id_pc.
REQ-014 Update on a hit:
- taken_a: counter increments and saturates at 3, and target is written with target_a;
- not taken_a: counter decrements and saturates at 0.
REQ-015 Update on a miss:
- taken_a: the entry is allocated (overwriting any occupant) with valid = 1, the tag and target_a; counter = 3 for jumps and 2 for branches;
- not taken: no allocation.
REQ-016 id_jumpr entries SHALL be updated like jumps, always with the latest id_rs target.
REQ-017 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update contents; the new value is visible from the next cycle.
REQ-018 The latency SHALL be 0 cycles from id_* inputs to redirect and 1 cycle to pc.

Reset
REQ-019 While rst_n = 0 the block SHALL hold the following state, asynchronously:
- pc = RESET_PC;
- all BTB valid bits = 0;
- all counters = 2'b01;
- targets and tags = 0.
REQ-020 While rst_n = 0 the outputs SHALL be pred_taken = 0, pred_target = 0, and flush_if = redirect = 0 when id_valid = 0.
REQ-021 Deassertion of rst_n SHALL be consumed synchronously: the first pc advance occurs on the first rising edge with rst_n = 1.
REQ-022 Asserting rst_n = 0 mid-operation SHALL discard any pending BTB update and any redirect.

Verification
REQ-023 Reset: release rst_n with stall = 0 and id_valid = 0 → pc goes BFC00000, BFC00004, BFC00008; pred_taken = 0 throughout.
REQ-024 Cold branch: id_pc = BFC00010, id_branch = 1, id_equ = 1, id_imme32 = 3, id_pred_taken = 0 →
- redirect = 1 and flush_if = 1 in the same cycle;
- next pc = BFC00020;
- later, fetch at BFC00010 → pred_taken = 1, pred_target = BFC00020.
REQ-025 Counter saturation: the same branch is resolved taken 3 times, then not-taken twice →
- the counter goes 2, 3, 3, 2, 1;
- pred_taken goes 0 after the second not-taken;
- the redirect on the not-taken mispredict goes to id_pc + 4.
REQ-026 Jr target change: jr at BFC00040, first with id_rs = 80000100, then with id_rs = 80000200 →
- the second resolution mispredicts (target mismatch) and redirects to 80000200;
- the BTB target is updated to 80000200.
REQ-027 Stall vs redirect: stall = 1 held for 3 cycles → pc constant; a mispredict during the stall → pc takes target_a on the next edge.
REQ-028 Aliasing and wrap:
- an entry for BFC00010 with BTB_ENTRIES = 16 is looked up at BFC00050 → tag mismatch, pred_taken = 0;
- pc = FFFFFFFC with no prediction → next pc = 00000000.
